// File: rtl/acumulador_de_teclas_pkg.sv
// Shared types and key codes for the keypad numeric-entry accumulator.
package acumulador_pkg;

  typedef enum logic [1:0] {
    ESPERA_TECLA  = 2'd0,
    PROCESSA      = 2'd1,
    ESPERA_SOLTAR = 2'd2
  } estado_t;

  localparam logic [3:0] TECLA_LIMPA    = 4'hF;
  localparam logic [3:0] TECLA_CONFIRMA = 4'hE;
  localparam logic [3:0] TECLA_APAGA    = 4'hA;

endpackage

// File: rtl/acumulador_de_teclas_if.sv
// Keypad-side inputs and accumulator results bundled as one port.
interface acumulador_de_teclas_if #(
  parameter int N_DIGITOS = 4
);
  localparam int W  = 4 * N_DIGITOS;
  localparam int NW = $clog2(N_DIGITOS + 1);

  logic [3:0]    tecla_value;
  logic          tecla_valid;
  logic [W-1:0]  digitos;
  logic [NW-1:0] num_digitos;
  logic [W-1:0]  valor;
  logic          valor_valid;
  logic          erro;
  logic          timeout;

  modport master (
    output tecla_value, tecla_valid,
    input  digitos, num_digitos, valor, valor_valid, erro, timeout
  );

  modport slave (
    input  tecla_value, tecla_valid,
    output digitos, num_digitos, valor, valor_valid, erro, timeout
  );
endinterface

// File: rtl/acumulador_de_teclas_temporizador_inatividade.sv
// Idle counter: raises expirou while enabled and the count sits at TIMEOUT_CICLOS-1.
module temporizador_inatividade #(
  parameter int TIMEOUT_CICLOS = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic habilita,
  input  logic zera,
  output logic expirou
);
  localparam int CW = $clog2(TIMEOUT_CICLOS);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (zera)          cnt_d = '0;
    else if (habilita) cnt_d = cnt_q + 1'b1;
  end

  assign expirou = habilita && (cnt_q == CW'(TIMEOUT_CICLOS - 1));

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/acumulador_de_teclas.sv
// BCD numeric-entry accumulator: one action per key press (digit, clear, backspace, confirm).
// Optional idle auto-clear compiled in with ACUMULADOR_TIMEOUT_EN.
module acumulador_de_teclas
  import acumulador_pkg::*;
#(
  parameter int N_DIGITOS      = 4,
  parameter int TIMEOUT_CICLOS = 50_000_000
) (
  input logic clk,
  input logic rst,
  acumulador_de_teclas_if.slave bus
);
  localparam int W  = 4 * N_DIGITOS;
  localparam int NW = $clog2(N_DIGITOS + 1);
  localparam logic [NW-1:0] MAX_D = NW'(N_DIGITOS);

  if (N_DIGITOS < 1 || N_DIGITOS > 8) begin : g_chk_n
    $error("N_DIGITOS out of range");
  end
  if (TIMEOUT_CICLOS < 2) begin : g_chk_t
    $error("TIMEOUT_CICLOS must be at least 2");
  end

  estado_t       state_q, state_d;
  logic [3:0]    tecla_q, tecla_d;
  logic [W-1:0]  digitos_q, digitos_d;
  logic [NW-1:0] num_q, num_d;
  logic [W-1:0]  valor_q, valor_d;
  logic          vv_q, vv_d;
  logic          erro_q, erro_d;
  logic          to_q, to_d;
  logic          expirou;

`ifdef ACUMULADOR_TIMEOUT_EN
  logic habilita, zera;
  assign habilita = (state_q == ESPERA_TECLA) && (num_q != '0);
  // A press latched on the expiry edge wins: the counter simply restarts.
  assign zera     = !habilita || bus.tecla_valid || expirou;

  temporizador_inatividade #(.TIMEOUT_CICLOS(TIMEOUT_CICLOS)) u_temporizador (
    .clk      (clk),
    .rst      (rst),
    .habilita (habilita),
    .zera     (zera),
    .expirou  (expirou)
  );
`else
  assign expirou = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    tecla_d   = tecla_q;
    digitos_d = digitos_q;
    num_d     = num_q;
    valor_d   = valor_q;
    vv_d      = 1'b0;
    erro_d    = 1'b0;
    to_d      = 1'b0;
    case (state_q)
      ESPERA_TECLA: begin
        if (bus.tecla_valid) begin
          tecla_d = bus.tecla_value;
          state_d = PROCESSA;
        end else if (expirou) begin
          digitos_d = '0;
          num_d     = '0;
          to_d      = 1'b1;
        end
      end
      PROCESSA: begin
        state_d = ESPERA_SOLTAR;
        if (tecla_q <= 4'd9) begin
          if (num_q < MAX_D) begin
            digitos_d = (digitos_q << 4) | W'(tecla_q);
            num_d     = num_q + 1'b1;
          end else begin
            erro_d = 1'b1;
          end
        end else begin
          case (tecla_q)
            TECLA_LIMPA: begin
              digitos_d = '0;
              num_d     = '0;
            end
            TECLA_CONFIRMA: begin
              if (num_q != '0) begin
                valor_d   = digitos_q;
                vv_d      = 1'b1;
                digitos_d = '0;
                num_d     = '0;
              end else begin
                erro_d = 1'b1;
              end
            end
            TECLA_APAGA: begin
              if (num_q != '0) begin
                digitos_d = digitos_q >> 4;
                num_d     = num_q - 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      default: begin
        if (!bus.tecla_valid) state_d = ESPERA_TECLA;
      end
    endcase
  end

  // Reset lands in ESPERA_SOLTAR so a key held through reset is ignored until released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ESPERA_SOLTAR;
      tecla_q   <= '0;
      digitos_q <= '0;
      num_q     <= '0;
      valor_q   <= '0;
      vv_q      <= 1'b0;
      erro_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tecla_q   <= tecla_d;
      digitos_q <= digitos_d;
      num_q     <= num_d;
      valor_q   <= valor_d;
      vv_q      <= vv_d;
      erro_q    <= erro_d;
      to_q      <= to_d;
    end
  end

  assign bus.digitos     = digitos_q;
  assign bus.num_digitos = num_q;
  assign bus.valor       = valor_q;
  assign bus.valor_valid = vv_q;
  assign bus.erro        = erro_q;
  assign bus.timeout     = to_q;
endmodule

// File: doc/acumulador_de_teclas.md
# acumulador_de_teclas

Numeric-entry accumulator sitting directly downstream of the 4x4 keypad decoder. Consumes its level-style `tecla_value`/`tecla_valid` pair and registers exactly one action per key press. Builds an N-digit BCD number from keys 0–9. Supports clear, backspace and confirm, and hands the confirmed number to the next stage with a one-cycle strobe.

## Interface
- `N_DIGITOS`, default 4: number of BCD digits held; valid range 1–8.
- `TIMEOUT_CICLOS`, default 50_000_000: idle cycles before auto-clear; used only when `ACUMULADOR_TIMEOUT_EN` is defined; must be at least 2.
- `clk` input, 1 bit: single clock; all logic on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `tecla_value` input, 4 bits: key code from the keypad decoder; meaningful only while `tecla_valid` = 1.
- `tecla_valid` input, 1 bit: high for as long as a debounced key is held.
- `digitos` output, 4*N_DIGITOS bits: current entry, BCD; digit 0 is in bits [3:0] and is the most recent digit.
- `num_digitos` output, $clog2(N_DIGITOS+1) bits: count of digits entered.
- `valor` output, 4*N_DIGITOS bits: last confirmed number; held until the next confirm.
- `valor_valid` output, 1 bit: one-cycle strobe when `valor` updates.
- `erro` output, 1 bit: one-cycle strobe on a rejected action.
- `timeout` output, 1 bit: one-cycle strobe on auto-clear; tied to 0 when the feature is compiled out.

## Operation
- Key map:
  - 0x0–0x9: digit.
  - 0xF (`*`): clear.
  - 0xE (`#`): confirm.
  - 0xA: backspace.
  - 0xB, 0xC, 0xD: ignored; no action, no `erro`.
- FSM states: ESPERA_TECLA, PROCESSA, ESPERA_SOLTAR.
  - ESPERA_TECLA: if `tecla_valid` = 1, latch `tecla_value` into an internal register and go to PROCESSA.
  - PROCESSA: perform the action for one cycle, then always go to ESPERA_SOLTAR.
  - ESPERA_SOLTAR: stay while `tecla_valid` = 1; go to ESPERA_TECLA when it is 0.
- One press produces exactly one action, however long the key is held.
- Digit action:
  - If `num_digitos` < N_DIGITOS: `digitos` <= {digitos[4*N_DIGITOS-5:0], key}; `num_digitos` +1.
  - If `num_digitos` = N_DIGITOS: buffer unchanged; `erro` pulses.
- Clear: `digitos` <= 0; `num_digitos` <= 0. Clearing an empty buffer is legal; no `erro`.
- Backspace:
  - If `num_digitos` > 0: `digitos` <= digitos >> 4; `num_digitos` −1.
  - If `num_digitos` = 0: no-op, no `erro`.
- Confirm:
  - If `num_digitos` > 0: `valor` <= `digitos`; `valor_valid` pulses; buffer cleared.
  - If `num_digitos` = 0: `erro` pulses; `valor` unchanged.
- Leading zeros count as digits: entering 0,0,7 gives `num_digitos` = 3.
- After reset the FSM starts in ESPERA_SOLTAR. A key held through reset is therefore ignored until it is released.
- `rst` during any state aborts the action in progress; no strobe is emitted that cycle.

## Timing
- Reset value of every output is 0: `digitos`, `num_digitos`, `valor`, `valor_valid`, `erro`, `timeout`.
- Latency: `tecla_valid` first sampled high at edge k.
  - Key latched at edge k.
  - `digitos`, `num_digitos` and `valor` update at edge k+1.
  - `valor_valid` or `erro` is high during the cycle following edge k+1, for exactly one cycle.
- `valor_valid` and `erro` are mutually exclusive.
- Minimum spacing between actions is 3 cycles: press, process, release.
- `tecla_value` changing while in ESPERA_SOLTAR has no effect.
- `tecla_valid` dropping during PROCESSA does not cancel the action.

## Configuration
- Macro: `ACUMULADOR_TIMEOUT_EN`.
- Defined:
  - An idle counter runs only in ESPERA_TECLA with `num_digitos` > 0.
  - The counter resets on entry to PROCESSA, and on clear or confirm.
  - When the count reaches TIMEOUT_CICLOS−1, the next edge clears the buffer and `timeout` pulses for one cycle.
  - If a press is latched on that same edge, the press wins: no timeout, and the counter resets.
- Undefined: no counter is instantiated; `timeout` = 0 constantly; the buffer persists indefinitely.

## Structure
- Package `acumulador_pkg` holds:
  - the state enum `estado_t` (ESPERA_TECLA, PROCESSA, ESPERA_SOLTAR);
  - key constants TECLA_LIMPA = 4'hF, TECLA_CONFIRMA = 4'hE, TECLA_APAGA = 4'hA.
- Sub-module `temporizador_inatividade` contains the timeout counter.
  - Ports: clk, rst, habilita, zera, expirou.
  - Parameter: TIMEOUT_CICLOS.
  - Instantiated only under `ACUMULADOR_TIMEOUT_EN`.

## Test plan
All scenarios use N_DIGITOS = 4; TIMEOUT_CICLOS = 20 where the timeout is used.
- Press keys 1, 2, 3, each held 10 cycles, then `#`:
  - `digitos` steps 0x0001 → 0x0012 → 0x0123;
  - `valor` = 0x0123 with one `valor_valid` pulse;
  - `digitos` = 0, `num_digitos` = 0.
- Hold key 5 for 200 cycles: exactly one action, `digitos` = 0x0005, `num_digitos` = 1.
- Enter 9, 8, 7, 6, then 4:
  - the fifth digit gives an `erro` pulse and `digitos` stays 0x9876;
  - then A gives 0x0987 with `num_digitos` = 3.
- `#` on an empty buffer gives an `erro` pulse, `valor` unchanged.
  - A on an empty buffer does nothing; `erro` stays 0.
  - B, C, D have no effect.
- Hold key 7 while `rst` is asserted, then deassert with the key still held: no action; release and press 7 again gives `digitos` = 0x0007.
- With `ACUMULADOR_TIMEOUT_EN` defined, enter 4 and then idle:
  - `timeout` pulses 20 cycles after entering ESPERA_TECLA and `digitos` = 0;
  - with the macro undefined, `digitos` stays 0x0004.
